cn_job_seq: RTL and testbench

- Job sequencer sitting directly upstream of the CryptoNight memory-loop top level.
- Consumes a 32-bit valid/ready job stream from the host bridge and replays it as register-slave writes: h0 state words, then R-variant op-code words, then the start command.
- Waits for the memory-loop finished strobe, reports completion and status, then accepts the next job.

---
 rtl/cn_seq_pkg.sv | 19 +
 rtl/cn_seq_edge.sv | 24 ++
 rtl/cn_job_seq.sv | 177 +++++++++++++++++
 tb/tb_cn_job_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cn_seq_pkg.sv
// Shared types and constants for the CryptoNight job sequencer.
package cn_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StH0,
        StCode,
        StStart,
        StWait,
        StDone
    } seq_state_e;

    localparam logic [9:0]  H0_BASE    = 10'h100;
    localparam logic [9:0]  CODE_BASE  = 10'h000;
    localparam logic [9:0]  START_ADDR = 10'h200;
    localparam int unsigned H0_WORDS   = 28;
    localparam logic [7:0]  H0_LAST    = 8'(H0_WORDS - 1);

endpackage

// File: rtl/cn_seq_edge.sv
// Rising-edge detector whose history register can be preloaded, so a level
// already high when detection starts does not count as an edge.
module cn_seq_edge (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    input  logic load,
    input  logic en,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else if (load || en) begin
            prev_q <= sig;
        end
    end

    assign rise = en && sig && !prev_q;

endmodule

// File: rtl/cn_job_seq.sv
// Job sequencer: replays a host job stream as register writes to the memory loop.
// Optional WAIT watchdog enabled by defining CN_SEQ_WATCHDOG_EN.
module cn_job_seq
    import cn_seq_pkg::*;
#(
    parameter int unsigned MAX_CODE       = 70,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h0100_0000,
    parameter logic [7:0]  MAGIC          = 8'hC4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] job_data,
    input  logic        job_valid,
    output logic        job_ready,
    output logic [9:0]  reg_address,
    output logic        reg_write,
    output logic [31:0] reg_wrdata,
    input  logic        ml_finished,
    output logic        busy,
    output logic        job_done,
    output logic        hdr_err,
    output logic        timeout,
    output logic [15:0] job_count
);

    localparam logic [6:0] MaxN = 7'(MAX_CODE);

    seq_state_e  state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [6:0]  n_q, n_d;
    logic [9:0]  reg_address_q, reg_address_d;
    logic        reg_write_q, reg_write_d;
    logic [31:0] reg_wrdata_q, reg_wrdata_d;
    logic        hdr_err_q, hdr_err_d;
    logic        ready_q, ready_d;
    logic [15:0] count_q, count_d;
    logic        timeout_q;

    logic accept, hdr_ok, hdr_accept, code_last, fin_rise, wd_fire;

    assign accept     = job_valid && ready_q;
    assign hdr_ok     = (job_data[31:24] == MAGIC) && (job_data[6:0] <= MaxN);
    assign hdr_accept = (state_q == StIdle) && accept && hdr_ok;
    assign code_last  = (idx_q == ({n_q, 1'b0} - 8'd1));

    cn_seq_edge u_fin_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (ml_finished),
        .load  (state_q == StStart),
        .en    (state_q == StWait),
        .rise  (fin_rise)
    );

`ifdef CN_SEQ_WATCHDOG_EN
    logic [31:0] wd_q;

    assign wd_fire = (state_q == StWait) && !fin_rise && (wd_q == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= (state_q == StWait) ? wd_q + 32'd1 : '0;
            if (wd_fire) begin
                timeout_q <= 1'b1;
            end else if (hdr_accept) begin
                timeout_q <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout;

    assign wd_fire        = 1'b0;
    assign timeout_q      = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            n_q           <= '0;
            reg_address_q <= '0;
            reg_write_q   <= 1'b0;
            reg_wrdata_q  <= '0;
            hdr_err_q     <= 1'b0;
            ready_q       <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            n_q           <= n_d;
            reg_address_q <= reg_address_d;
            reg_write_q   <= reg_write_d;
            reg_wrdata_q  <= reg_wrdata_d;
            hdr_err_q     <= hdr_err_d;
            ready_q       <= ready_d;
            count_q       <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (hdr_accept) state_d = StH0;
            StH0: begin
                if (accept && idx_q == H0_LAST) begin
                    state_d = (n_q != 7'd0) ? StCode : StStart;
                end
            end
            StCode:  if (accept && code_last) state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (fin_rise || wd_fire) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idx_d         = idx_q;
        n_d           = n_q;
        reg_address_d = reg_address_q;
        reg_write_d   = 1'b0;
        reg_wrdata_d  = reg_wrdata_q;
        hdr_err_d     = 1'b0;
        count_d       = count_q;
        ready_d       = (state_d == StIdle) || (state_d == StH0) || (state_d == StCode);
        unique case (state_q)
            StIdle: begin
                if (hdr_accept) begin
                    n_d   = job_data[6:0];
                    idx_d = '0;
                end else if (accept) begin
                    hdr_err_d = 1'b1;
                end
            end
            StH0: begin
                if (accept) begin
                    reg_write_d   = 1'b1;
                    reg_address_d = H0_BASE | {5'b0, idx_q[4:0]};
                    reg_wrdata_d  = job_data;
                    idx_d         = (idx_q == H0_LAST) ? 8'd0 : idx_q + 8'd1;
                end
            end
            StCode: begin
                if (accept) begin
                    reg_write_d   = 1'b1;
                    reg_address_d = CODE_BASE | {2'b0, idx_q};
                    reg_wrdata_d  = job_data;
                    idx_d         = idx_q + 8'd1;
                end
            end
            StStart: begin
                reg_write_d   = 1'b1;
                reg_address_d = START_ADDR;
                reg_wrdata_d  = 32'h1;
            end
            // An aborted job reaches DONE with timeout already set.
            StDone:  if (!timeout_q) count_d = count_q + 16'd1;
            default: ;
        endcase
    end

    assign job_ready   = ready_q;
    assign reg_address = reg_address_q;
    assign reg_write   = reg_write_q;
    assign reg_wrdata  = reg_wrdata_q;
    assign busy        = (state_q != StIdle);
    assign job_done    = (state_q == StDone);
    assign hdr_err     = hdr_err_q;
    assign timeout     = timeout_q;
    assign job_count   = count_q;

endmodule

// File: tb/tb_cn_job_seq.sv
// Self-checking bench for cn_job_seq: table of jobs plus hand-written corner sequences.
module tb_cn_job_seq;

`ifdef CN_SEQ_WATCHDOG_EN
    localparam logic [31:0] TMO = 32'd100;
`else
    localparam logic [31:0] TMO = 32'h0100_0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] job_data = '0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [9:0]  reg_address;
    logic        reg_write;
    logic [31:0] reg_wrdata;
    logic        ml_finished = 1'b0;
    logic        busy, job_done, hdr_err, timeout;
    logic [15:0] job_count;

    cn_job_seq #(
        .MAX_CODE       (70),
        .TIMEOUT_CYCLES (TMO),
        .MAGIC          (8'hC4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .job_data    (job_data),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .reg_address (reg_address),
        .reg_write   (reg_write),
        .reg_wrdata  (reg_wrdata),
        .ml_finished (ml_finished),
        .busy        (busy),
        .job_done    (job_done),
        .hdr_err     (hdr_err),
        .timeout     (timeout),
        .job_count   (job_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;

    wr_t wlog[$];
    int  err_pulses = 0;
    int  done_pulses = 0;

    always @(negedge clk) begin
        if (reg_write) wlog.push_back('{reg_address, reg_wrdata, cyc});
        if (hdr_err) err_pulses <= err_pulses + 1;
        if (job_done) done_pulses <= done_pulses + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit slow);
        bit ok;
        ok = 1'b0;
        if (slow) begin
            job_valid = 1'b0;
            tick(2);
        end
        job_data  = w;
        job_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = job_ready;
            tick(1);
        end
        job_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_payload(input int n, input bit slow);
        for (int i = 0; i < 28; i++) send_word(32'h100 + i, slow);
        for (int i = 0; i < 2 * n; i++) send_word(32'hA0 + i, slow);
    endtask

    // Expected writes: h0 block, code block, then the start command.
    task automatic check_writes(input int n);
        logic [9:0]  ea;
        logic [31:0] ed;
        int          tot;
        tot = 29 + 2 * n;
        check("wr_count", wlog.size(), tot);
        for (int k = 0; k < tot && k < wlog.size(); k++) begin
            if (k < 28) begin
                ea = 10'h100 + 10'(k);
                ed = 32'h100 + k;
            end else if (k < 28 + 2 * n) begin
                ea = 10'(k - 28);
                ed = 32'hA0 + (k - 28);
            end else begin
                ea = 10'h200;
                ed = 32'h1;
            end
            check("wr_addr", wlog[k].a, ea);
            check("wr_data", wlog[k].d, ed);
        end
    endtask

    task automatic finish_job();
        ml_finished = 1'b1;
        tick(1);
        check("job_done_pulse", job_done, 1'b1);
        ml_finished = 1'b0;
        tick(1);
        exp_cnt++;
        check("job_done_single", job_done, 1'b0);
        check("job_count", job_count, exp_cnt);
        check("idle_after_done", busy, 1'b0);
    endtask

    typedef struct {
        logic [31:0] hdr;
        bit          slow;
        bit          bad;
        int          fin_dly;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int e0, d0, n, c0;
        vecs[0] = '{32'hC400_0002, 1'b0, 1'b0, 50};
        vecs[1] = '{32'hC400_0000, 1'b0, 1'b0, 5};
        vecs[2] = '{32'hB300_0001, 1'b0, 1'b1, 0};
        vecs[3] = '{32'hC400_0047, 1'b0, 1'b1, 0};
        vecs[4] = '{32'hC400_0002, 1'b1, 1'b0, 10};
        vecs[5] = '{32'hC400_0046, 1'b0, 1'b0, 3};

        tick(2);
        check("rst_job_ready", job_ready, 1'b0);
        check("rst_reg_write", reg_write, 1'b0);
        check("rst_reg_addr", reg_address, 10'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", job_count, 16'h0);
        check("rst_timeout", timeout, 1'b0);
        reset = 1'b0;
        tick(2);
        check("ready_after_rst", job_ready, 1'b1);

        for (int i = 0; i < 6; i++) begin
            wlog.delete();
            e0 = err_pulses;
            d0 = done_pulses;
            n  = int'(vecs[i].hdr[6:0]);
            send_word(vecs[i].hdr, vecs[i].slow);
            if (vecs[i].bad) begin
                tick(2);
                check("hdr_err_pulse", err_pulses, e0 + 1);
                check("bad_no_write", wlog.size(), 0);
                check("bad_stays_idle", busy, 1'b0);
                check("bad_ready", job_ready, 1'b1);
            end else begin
                check("busy_after_hdr", busy, 1'b1);
                send_payload(n, vecs[i].slow);
                tick(3);
                check_writes(n);
                if (n == 0 && wlog.size() == 29)
                    check("start_follows_h0", wlog[28].c - wlog[27].c, 1);
                check("wait_not_ready", job_ready, 1'b0);
                tick(vecs[i].fin_dly);
                check("no_early_done", done_pulses, d0);
                check("busy_in_wait", busy, 1'b1);
                finish_job();
            end
        end

        // ml_finished level held from the previous job must not complete the next one.
        wlog.delete();
        send_word(32'hC400_0000, 1'b0);
        send_payload(0, 1'b0);
        tick(5);
        ml_finished = 1'b1;
        tick(1);
        check("held_first_done", job_done, 1'b1);
        tick(1);
        exp_cnt++;
        check("held_first_count", job_count, exp_cnt);
        d0 = done_pulses;
        send_word(32'hC400_0000, 1'b0);
        send_payload(0, 1'b0);
        tick(20);
        check("held_level_ignored", done_pulses, d0);
        check("held_still_wait", busy, 1'b1);
        ml_finished = 1'b0;
        tick(3);
        check("held_fall_ignored", done_pulses, d0);
        finish_job();

`ifdef CN_SEQ_WATCHDOG_EN
        wlog.delete();
        send_word(32'hC400_0000, 1'b0);
        send_payload(0, 1'b0);
        tick(3);
        c0 = (wlog.size() > 0) ? wlog[wlog.size() - 1].c : 0;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 300 && !seen; k++) begin
                if (job_done) seen = 1'b1;
                else tick(1);
            end
            check("wd_done_seen", seen, 1'b1);
            check("wd_cycle", cyc - c0, 100);
            check("wd_timeout", timeout, 1'b1);
        end
        tick(1);
        check("wd_count_same", job_count, exp_cnt);
        check("wd_idle", busy, 1'b0);
        check("wd_sticky", timeout, 1'b1);
        send_word(32'hC400_0000, 1'b0);
        check("wd_clear_on_hdr", timeout, 1'b0);
        send_payload(0, 1'b0);
        tick(3);
        finish_job();
`else
        c0 = 0;
        check("no_wd_timeout", timeout, 1'b0);
`endif

        // Reset in the middle of the h0 phase.
        send_word(32'hC400_0001, 1'b0);
        for (int i = 0; i < 5; i++) send_word(32'h100 + i, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_write", reg_write, 1'b0);
        check("mid_rst_addr", reg_address, 10'h0);
        check("mid_rst_data", reg_wrdata, 32'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", job_ready, 1'b0);
        check("mid_rst_count", job_count, 16'h0);
        check("mid_rst_done", job_done, 1'b0);
        tick(1);
        reset = 1'b0;
        exp_cnt = 0;
        wlog.delete();
        send_word(32'hC400_0001, 1'b0);
        send_payload(1, 1'b0);
        tick(3);
        check_writes(1);
        finish_job();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, got %0d cycles", cyc);
        $fatal(1);
    end

endmodule
